// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tpu_pkg
//  Purpose  : Shared types and constants for the pe-array operand feeder.
//             DATA_W         - operand width (two's complement)
//             operand_t      - one signed operand
//             feeder_state_t - feeder sequencing states
//  Revision : 1.0 - initial release
// ============================================================================
package tpu_pkg;

    localparam int DATA_W = 8;

    typedef logic signed [DATA_W-1:0] operand_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/skew_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : skew_delay_line
//  Purpose  : Fixed-depth, never-stalling shift register for one feeder lane.
//             The input appears on the output DEPTH cycles later.
//  Ports    : clk       - clock
//             rst       - synchronous active-low clear of every stage
//             data_in   - operand entering the line
//             valid_in  - qualifier for data_in
//             data_out  - operand leaving the line
//             valid_out - qualifier for data_out
//  Revision : 1.0 - initial release
// ============================================================================
module skew_delay_line
    import tpu_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out
);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= '0;
            end
            r_valid <= '0;
        end else begin
            r_data[0]  <= data_in;
            r_valid[0] <= valid_in;
            for (int k = 1; k < DEPTH; k++) begin
                r_data[k]  <= r_data[k-1];
                r_valid[k] <= r_valid[k-1];
            end
        end
    end

    assign data_out  = r_data[DEPTH-1];
    assign valid_out = r_valid[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_skew_feeder
//  Purpose  : Accepts one N-lane row vector of signed operands per beat and
//             drives the pe-array edge with a diagonal skew (lane i delayed
//             i extra cycles). Sequences one tile of k_len beats: pulses
//             acc_clr before the first beat, drains the skew pipeline, then
//             pulses tile_done as lane N-1 presents the last beat.
//  Ports    : clk, rst (sync, active-low)
//             start, k_len       - tile request, sampled only in IDLE
//             busy               - tile in progress (FEED or DRAIN)
//             in_valid/in_ready  - beat handshake, in_data lane i at
//                                  [i*DATA_W +: DATA_W]
//             out_data/out_valid - skewed operands, zero when lane invalid
//             acc_clr            - one-cycle pulse in the first FEED cycle
//             tile_done          - one-cycle pulse at end of tile
//             stall_cnt          - FEED cycles without in_valid (optional)
//  Options  : FEEDER_STALL_CNT_EN - adds the saturating stall_cnt output
//  Revision : 1.0 - initial release
// ============================================================================
module systolic_skew_feeder #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int K_MAX  = 16,
    parameter int KW     = $clog2(K_MAX + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KW-1:0]       k_len,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DATA_W-1:0] in_data,
    output logic [N*DATA_W-1:0] out_data,
    output logic [N-1:0]        out_valid,
    output logic                acc_clr,
    output logic                tile_done
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]         stall_cnt
`endif
);

    import tpu_pkg::*;

    // Drain counter covers the cycles between the last accept and the
    // cycle in which lane N-1 presents that beat.
    localparam int c_drain_w = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_drain_w-1:0] c_drain_last = c_drain_w'(N - 1);
    localparam logic [c_drain_w-1:0] c_done_pre   = c_drain_w'((N > 1) ? (N - 2) : 0);

    feeder_state_t          r_state;
    logic [KW-1:0]          r_k_len;
    logic [KW-1:0]          r_beat_cnt;
    logic [c_drain_w-1:0]   r_drain_cnt;
    logic                   r_acc_clr;
    logic                   r_tile_done;

    logic                   w_start_ok;
    logic                   w_accept;
    logic                   w_last_beat;

    assign w_start_ok  = start && (k_len != '0) && (int'(k_len) <= K_MAX);
    assign w_accept    = in_valid && (r_state == FEED);
    assign w_last_beat = (r_beat_cnt == r_k_len - KW'(1));

    // Sequencer
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_k_len     <= '0;
            r_beat_cnt  <= '0;
            r_drain_cnt <= '0;
            r_acc_clr   <= 1'b0;
            r_tile_done <= 1'b0;
        end else begin
            r_acc_clr   <= 1'b0;
            r_tile_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_k_len    <= k_len;
                        r_beat_cnt <= '0;
                        r_acc_clr  <= 1'b1;
                        r_state    <= FEED;
                    end
                end
                FEED: begin
                    if (w_accept) begin
                        if (w_last_beat) begin
                            r_beat_cnt  <= '0;
                            r_drain_cnt <= '0;
                            if (N == 1) begin
                                // Single lane: lane 0 shows the beat next cycle.
                                r_tile_done <= 1'b1;
                                r_state     <= IDLE;
                            end else begin
                                r_state <= DRAIN;
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt + KW'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Registered pulse lands in the final DRAIN cycle.
                    if (r_drain_cnt == c_done_pre) begin
                        r_tile_done <= 1'b1;
                    end
                    if (r_drain_cnt == c_drain_last) begin
                        r_drain_cnt <= '0;
                        r_state     <= IDLE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + c_drain_w'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign in_ready  = (r_state == FEED);
    assign acc_clr   = r_acc_clr;
    assign tile_done = r_tile_done;

    // Lane i delay line has depth i+1. Non-accepted cycles inject a zero
    // operand with valid low so downstream accumulation is unaffected.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DATA_W-1:0] w_lane_in;

        assign w_lane_in = w_accept ? in_data[i*DATA_W +: DATA_W] : '0;

        skew_delay_line #(
            .DEPTH (i + 1),
            .WIDTH (DATA_W)
        ) u_delay (
            .clk       (clk),
            .rst       (rst),
            .data_in   (w_lane_in),
            .valid_in  (w_accept),
            .data_out  (out_data[i*DATA_W +: DATA_W]),
            .valid_out (out_valid[i])
        );
    end

`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if ((r_state == IDLE) && w_start_ok) begin
            r_stall_cnt <= '0;
        end else if ((r_state == FEED) && !in_valid && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_skew_feeder
//  Purpose  : Directed self-checking bench for systolic_skew_feeder (N=4).
//             Inputs are driven and outputs sampled on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_skew_feeder;

    localparam int N      = 4;
    localparam int DATA_W = 8;
    localparam int K_MAX  = 16;
    localparam int KW     = $clog2(K_MAX + 1);

    logic                clk;
    logic                rst;
    logic                start;
    logic [KW-1:0]       k_len;
    logic                busy;
    logic                in_valid;
    logic                in_ready;
    logic [N*DATA_W-1:0] in_data;
    logic [N*DATA_W-1:0] out_data;
    logic [N-1:0]        out_valid;
    logic                acc_clr;
    logic                tile_done;
`ifdef FEEDER_STALL_CNT_EN
    logic [15:0]         stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    systolic_skew_feeder #(
        .N      (N),
        .DATA_W (DATA_W),
        .K_MAX  (K_MAX),
        .KW     (KW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .acc_clr   (acc_clr),
        .tile_done (tile_done)
`ifdef FEEDER_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full output snapshot for one cycle.
    task automatic expect_cycle(input string tag, input logic [3:0] ev, input logic [31:0] ed,
                                input logic acc, input logic done, input logic bsy, input logic rdy);
        chk({tag, ".out_valid"}, {28'd0, out_valid}, {28'd0, ev});
        chk({tag, ".out_data"},  out_data, ed);
        chk({tag, ".acc_clr"},   {31'd0, acc_clr},   {31'd0, acc});
        chk({tag, ".tile_done"}, {31'd0, tile_done}, {31'd0, done});
        chk({tag, ".busy"},      {31'd0, busy},      {31'd0, bsy});
        chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, rdy});
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] d);
        in_valid = v;
        in_data  = d;
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        k_len    = '0;
        in_valid = 1'b0;
        in_data  = '0;

        // ---------------- reset state ----------------
        tick(); tick();
        expect_cycle("reset", 4'b0000, 32'h0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        expect_cycle("idle", 4'b0000, 32'h0, 0, 0, 0, 0);

        // ---------------- basic tile, k_len=3 ----------------
        start = 1'b1; k_len = 5'd3;
        tick(); start = 1'b0; k_len = '0;
        expect_cycle("t1.F0", 4'b0000, 32'h0, 1, 0, 1, 1);
        drive(1, 32'h04030201);
        tick(); expect_cycle("t1.F1", 4'b0001, 32'h00000001, 0, 0, 1, 1);
        drive(1, 32'h08070605);
        tick(); expect_cycle("t1.F2", 4'b0011, 32'h00000205, 0, 0, 1, 1);
        drive(1, 32'h0C0B0A09);
        tick(); expect_cycle("t1.F3", 4'b0111, 32'h00030609, 0, 0, 1, 0);
        drive(1, 32'hFFFFFFFF);   // must be ignored, in_ready is low
        tick(); expect_cycle("t1.F4", 4'b1110, 32'h04070A00, 0, 0, 1, 0);
        drive(0, 32'h0);
        tick(); expect_cycle("t1.F5", 4'b1100, 32'h080B0000, 0, 0, 1, 0);
        tick(); expect_cycle("t1.F6", 4'b1000, 32'h0C000000, 0, 1, 1, 0);
        tick(); expect_cycle("t1.F7", 4'b0000, 32'h0, 0, 0, 0, 0);

        // ---------------- bubble tile ----------------
        start = 1'b1; k_len = 5'd3;
        tick(); start = 1'b0;
        expect_cycle("t2.F0", 4'b0000, 32'h0, 1, 0, 1, 1);
        drive(1, 32'h04030201);
        tick(); expect_cycle("t2.F1", 4'b0001, 32'h00000001, 0, 0, 1, 1);
        drive(0, 32'hAAAAAAAA);
        tick(); expect_cycle("t2.F2", 4'b0010, 32'h00000200, 0, 0, 1, 1);
        drive(0, 32'h55555555);
        tick(); expect_cycle("t2.F3", 4'b0100, 32'h00030000, 0, 0, 1, 1);
        drive(1, 32'h08070605);
        tick(); expect_cycle("t2.F4", 4'b1001, 32'h04000005, 0, 0, 1, 1);
        drive(1, 32'h0C0B0A09);
        tick(); expect_cycle("t2.F5", 4'b0011, 32'h00000609, 0, 0, 1, 0);
        drive(0, 32'h0);
        tick(); expect_cycle("t2.F6", 4'b0110, 32'h00070A00, 0, 0, 1, 0);
        tick(); expect_cycle("t2.F7", 4'b1100, 32'h080B0000, 0, 0, 1, 0);
        tick(); expect_cycle("t2.F8", 4'b1000, 32'h0C000000, 0, 1, 1, 0);
        tick(); expect_cycle("t2.F9", 4'b0000, 32'h0, 0, 0, 0, 0);
`ifdef FEEDER_STALL_CNT_EN
        chk("t2.stall_cnt", {16'd0, stall_cnt}, 32'd2);
`endif

        // ---------------- signed passthrough, k_len=1 ----------------
        start = 1'b1; k_len = 5'd1;
        tick(); start = 1'b0;
        expect_cycle("t3.F0", 4'b0000, 32'h0, 1, 0, 1, 1);
        drive(1, 32'h0000FCF6);
        tick(); expect_cycle("t3.F1", 4'b0001, 32'h000000F6, 0, 0, 1, 0);
        drive(0, 32'h0);
        tick(); expect_cycle("t3.F2", 4'b0010, 32'h0000FC00, 0, 0, 1, 0);
        tick(); expect_cycle("t3.F3", 4'b0100, 32'h0, 0, 0, 1, 0);
        tick(); expect_cycle("t3.F4", 4'b1000, 32'h0, 0, 1, 1, 0);
        tick(); expect_cycle("t3.F5", 4'b0000, 32'h0, 0, 0, 0, 0);

        // ---------------- illegal k_len values ignored ----------------
        start = 1'b1; k_len = 5'd0;
        tick(); expect_cycle("t4.k0a", 4'b0000, 32'h0, 0, 0, 0, 0);
        k_len = 5'd17;
        tick(); expect_cycle("t4.k17", 4'b0000, 32'h0, 0, 0, 0, 0);
        start = 1'b0; k_len = '0;
        tick(); expect_cycle("t4.k0b", 4'b0000, 32'h0, 0, 0, 0, 0);

        // ---------------- start during DRAIN ignored ----------------
        start = 1'b1; k_len = 5'd1;
        tick(); start = 1'b0;
        expect_cycle("t5.F0", 4'b0000, 32'h0, 1, 0, 1, 1);
        drive(1, 32'h44332211);
        tick(); expect_cycle("t5.F1", 4'b0001, 32'h00000011, 0, 0, 1, 0);
        drive(0, 32'h0);
        start = 1'b1; k_len = 5'd2;
        tick(); expect_cycle("t5.F2", 4'b0010, 32'h00002200, 0, 0, 1, 0);
        start = 1'b0; k_len = '0;
        tick(); expect_cycle("t5.F3", 4'b0100, 32'h00330000, 0, 0, 1, 0);
        tick(); expect_cycle("t5.F4", 4'b1000, 32'h44000000, 0, 1, 1, 0);
        tick(); expect_cycle("t5.F5", 4'b0000, 32'h0, 0, 0, 0, 0);
        tick(); expect_cycle("t5.F6", 4'b0000, 32'h0, 0, 0, 0, 0);

        // ---------------- reset mid-FEED ----------------
        start = 1'b1; k_len = 5'd3;
        tick(); start = 1'b0;
        expect_cycle("t6.F0", 4'b0000, 32'h0, 1, 0, 1, 1);
        drive(1, 32'h04030201);
        tick(); expect_cycle("t6.F1", 4'b0001, 32'h00000001, 0, 0, 1, 1);
        drive(1, 32'h08070605);
        rst = 1'b0;
        tick(); expect_cycle("t6.rst", 4'b0000, 32'h0, 0, 0, 0, 0);
        rst = 1'b1;
        drive(0, 32'h0);
        for (int c = 0; c < 6; c++) begin
            tick();
            expect_cycle("t6.quiet", 4'b0000, 32'h0, 0, 0, 0, 0);
        end

        // fresh k_len=1 tile after the abandoned one
        start = 1'b1; k_len = 5'd1;
        tick(); start = 1'b0;
        expect_cycle("t7.F0", 4'b0000, 32'h0, 1, 0, 1, 1);
        drive(1, 32'h81C07F01);
        tick(); expect_cycle("t7.F1", 4'b0001, 32'h00000001, 0, 0, 1, 0);
        drive(0, 32'h0);
        tick(); expect_cycle("t7.F2", 4'b0010, 32'h00007F00, 0, 0, 1, 0);
        tick(); expect_cycle("t7.F3", 4'b0100, 32'h00C00000, 0, 0, 1, 0);
        tick(); expect_cycle("t7.F4", 4'b1000, 32'h81000000, 0, 1, 1, 0);
        tick(); expect_cycle("t7.F5", 4'b0000, 32'h0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
